// File: rtl/uart_buffer_axi.sv
// AXI4-Lite responder for the UART window: RX/TX byte FIFOs behind a 4-register map.
// Reads of an empty RX FIFO and writes to a full TX FIFO stall the response.

module uart_buffer_axi_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  logic [7:0]            mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;

  // Flush has priority over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  // count never exceeds the depth, so its MSB alone marks full.
  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = count[DEPTH_LOG2];

endmodule

module uart_buffer_axi #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [2:0]  s_axi_arprot,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [2:0]  s_axi_awprot,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [3:0] A_RX   = 4'h0;
  localparam logic [3:0] A_TX   = 4'h4;
  localparam logic [3:0] A_STAT = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hC;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_t;

  rd_state_t rstate, rstate_nxt;
  wr_state_t wstate, wstate_nxt;

  logic        live;
  logic [3:0]  raddr;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        ar_hs, r_stall, r_load;
  logic [3:0]  waddr;
  logic [7:0]  wdata_q;
  logic        wstrb0_q, aw_done, w_done;
  logic        aw_hs, w_hs, w_stall, w_do, w_addr_ok;

  logic       rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic [7:0] rx_head;
  logic       tx_push, tx_pop, tx_flush, tx_empty, tx_full;

  logic unused_ok;
  assign unused_ok = ^{s_axi_arprot, s_axi_awprot, s_axi_wdata[31:8], s_axi_wstrb[3:1]};

  // Holds every *ready low until the first edge after reset is released.
  always_ff @(posedge clk) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  uart_buffer_axi_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(rx_flush), .push(rx_push), .push_data(rx_data),
    .pop(rx_pop), .head(rx_head), .empty(rx_empty), .full(rx_full)
  );

  uart_buffer_axi_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(tx_flush), .push(tx_push), .push_data(wdata_q),
    .pop(tx_pop), .head(tx_data), .empty(tx_empty), .full(tx_full)
  );

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;

  // ---------------- read channel ----------------
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_stall = (raddr == A_RX) && rx_empty;

  always_ff @(posedge clk) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_WAIT;
      R_WAIT:  if (!r_stall) rstate_nxt = R_RESP;
      R_RESP:  if (s_axi_rready) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = live && (rstate == R_IDLE);
    s_axi_rvalid  = (rstate == R_RESP);
    r_load        = (rstate == R_WAIT) && !r_stall;
    rx_pop        = r_load && (raddr == A_RX);
  end

  always_comb begin
    rd_word = '0;
    rd_resp = OKAY;
    case (raddr)
      A_RX:          rd_word = {24'b0, rx_head};
      A_STAT:        rd_word = {28'b0, tx_full, tx_empty, rx_full, !rx_empty};
      A_TX, A_CTRL:  ;
      default:       rd_resp = SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr       <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
    end else begin
      if (ar_hs) raddr <= s_axi_araddr;
      if (r_load) begin
        s_axi_rdata <= rd_word;
        s_axi_rresp <= rd_resp;
      end
    end
  end

  // ---------------- write channel ----------------
  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign w_addr_ok = (waddr == A_RX) || (waddr == A_TX) || (waddr == A_STAT) || (waddr == A_CTRL);
  // A same-cycle PHY pop frees the slot the stalled write needs.
  assign w_stall   = (waddr == A_TX) && wstrb0_q && tx_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if ((aw_done || aw_hs) && (w_done || w_hs)) wstate_nxt = W_EXEC;
      W_EXEC:  if (!w_stall) wstate_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = live && (wstate == W_IDLE) && !aw_done;
    s_axi_wready  = live && (wstate == W_IDLE) && !w_done;
    s_axi_bvalid  = (wstate == W_RESP);
    w_do          = (wstate == W_EXEC) && !w_stall;
    tx_push       = w_do && (waddr == A_TX) && wstrb0_q;
    tx_flush      = w_do && (waddr == A_CTRL) && wstrb0_q && wdata_q[0];
    rx_flush      = w_do && (waddr == A_CTRL) && wstrb0_q && wdata_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      waddr       <= '0;
      wdata_q     <= '0;
      wstrb0_q    <= 1'b0;
      s_axi_bresp <= '0;
    end else begin
      if (aw_hs) begin
        waddr   <= s_axi_awaddr;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wdata_q  <= s_axi_wdata[7:0];
        wstrb0_q <= s_axi_wstrb[0];
        w_done   <= 1'b1;
      end
      if (w_do) s_axi_bresp <= w_addr_ok ? OKAY : SLVERR;
      if (s_axi_bvalid && s_axi_bready) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_buffer_axi.sv
// Scoreboard bench for uart_buffer_axi: queue-based FIFO model, directed cases then random traffic.

module tb_uart_buffer_axi;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [2:0]  s_axi_arprot;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [2:0]  s_axi_awprot;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  uart_buffer_axi #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_arprot(s_axi_arprot), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awprot(s_axi_awprot), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t      exp_r[$];
  logic [1:0] exp_b[$];
  logic [7:0] model_rx[$];
  logic [7:0] model_tx[$];
  rexp_t      mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stat_exp();
    return {28'b0, model_tx.size() == DEPTH, model_tx.size() == 0,
            model_rx.size() == DEPTH, model_rx.size() != 0};
  endfunction

  function automatic rexp_t read_model(input logic [3:0] a);
    rexp_t e;
    e.data = '0;
    e.resp = 2'b00;
    case (a)
      4'h0:       e.data = {24'b0, model_rx.pop_front()};
      4'h8:       e.data = stat_exp();
      4'h4, 4'hC: ;
      default:    e.resp = 2'b10;
    endcase
    return e;
  endfunction

  // Monitors: sample away from the active edge and score every presented response/byte.
  always @(negedge clk) begin
    if (s_axi_rvalid && s_axi_rready) begin
      if (exp_r.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rvalid: got rdata 0x%0h, expected no response", s_axi_rdata);
      end else begin
        mon_e = exp_r.pop_front();
        check("rdata", s_axi_rdata, mon_e.data);
        check("rresp", {30'b0, s_axi_rresp}, {30'b0, mon_e.resp});
      end
    end
    if (s_axi_bvalid && s_axi_bready) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_bvalid: got bresp %0d, expected no response", s_axi_bresp);
      end else begin
        check("bresp", {30'b0, s_axi_bresp}, {30'b0, exp_b.pop_front()});
      end
    end
    if (tx_valid && tx_ready) begin
      if (model_tx.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_tx: got tx_data 0x%0h, expected empty TX", tx_data);
      end else begin
        check("tx_data", {24'b0, tx_data}, {24'b0, model_tx.pop_front()});
      end
    end
  end

  task automatic start_read(input logic [3:0] a);
    int   n;
    logic hs;
    n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_axi_arready;
      step();
      if (hs) break;
      n++;
      if (n > 40) begin timeout("ar_handshake"); break; end
    end
    s_axi_arvalid = 1'b0;
  endtask

  // lat = number of falling edges after the handshake edge until valid is seen.
  task automatic wait_valid(input bit is_read, input int budget, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (is_read ? s_axi_rvalid : s_axi_bvalid) begin
        step();
        break;
      end
      if (lat >= budget) begin
        timeout(is_read ? "rvalid_wait" : "bvalid_wait");
        step();
        break;
      end
      step();
    end
  endtask

  task automatic do_read(input logic [3:0] a, input string name);
    int lat;
    exp_r.push_back(read_model(a));
    start_read(a);
    wait_valid(1'b1, 40, lat);
    check({name, "_lat"}, lat, 2);
  endtask

  // gap: +1 AW one cycle before W, -1 W before AW, 0 same cycle.
  task automatic start_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int gap);
    bit aw_d, w_d, aw_h, w_h;
    int c, aw_start, w_start;
    aw_d = 0; w_d = 0; c = 0;
    aw_start = (gap < 0) ? 1 : 0;
    w_start  = (gap > 0) ? 1 : 0;
    exp_b.push_back((a inside {4'h0, 4'h4, 4'h8, 4'hC}) ? 2'b00 : 2'b10);
    if (s[0]) begin
      if (a == 4'h4) model_tx.push_back(d[7:0]);
      if (a == 4'hC) begin
        if (d[0]) model_tx.delete();
        if (d[1]) model_rx.delete();
      end
    end
    s_axi_awaddr = a;
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    while (!(aw_d && w_d)) begin
      if (c > 40) begin timeout("aw_w_capture"); break; end
      s_axi_awvalid = !aw_d && (c >= aw_start);
      s_axi_wvalid  = !w_d && (c >= w_start);
      @(negedge clk);
      aw_h = s_axi_awvalid && s_axi_awready;
      w_h  = s_axi_wvalid && s_axi_wready;
      step();
      if (aw_h) aw_d = 1;
      if (w_h)  w_d = 1;
      c++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int gap, input string name);
    int lat;
    start_write(a, d, s, gap);
    wait_valid(1'b0, 40, lat);
    check({name, "_lat"}, lat, 2);
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic acc;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    acc = rx_ready;
    check("rx_ready", {31'b0, rx_ready}, {31'b0, model_rx.size() < DEPTH});
    step();
    rx_valid = 1'b0;
    if (acc) model_rx.push_back(b);
  endtask

  task automatic check_reset_outs();
    check("rst_arready", {31'b0, s_axi_arready}, 0);
    check("rst_awready", {31'b0, s_axi_awready}, 0);
    check("rst_wready",  {31'b0, s_axi_wready},  0);
    check("rst_rvalid",  {31'b0, s_axi_rvalid},  0);
    check("rst_bvalid",  {31'b0, s_axi_bvalid},  0);
    check("rst_rdata",   s_axi_rdata, 0);
    check("rst_rresp",   {30'b0, s_axi_rresp}, 0);
    check("rst_bresp",   {30'b0, s_axi_bresp}, 0);
    check("rst_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_rx_ready", {31'b0, rx_ready}, 1);
  endtask

  task automatic check_readies_up();
    @(negedge clk);
    check("arready_up", {31'b0, s_axi_arready}, 1);
    check("awready_up", {31'b0, s_axi_awready}, 1);
    check("wready_up",  {31'b0, s_axi_wready},  1);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   lat;
    bit   seen;
    logic [3:0] a;
    logic [7:0] b;

    rst = 1'b1;
    s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_arprot = '0; s_axi_rready = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_awprot = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 1'b1;
    rx_data = '0; rx_valid = 0; tx_ready = 0;

    step(); step();
    @(negedge clk);
    check_reset_outs();
    step();
    rst = 1'b0;
    step();
    check_readies_up();

    do_read(4'h8, "stat_reset");

    // TX write with AW leading W, then one PHY pop.
    do_write(4'h4, 32'h41, 4'hF, 1, "tx_write");
    @(negedge clk);
    check("tx_valid_after_write", {31'b0, tx_valid}, 1);
    check("tx_head", {24'b0, tx_data}, 32'h41);
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    check("tx_valid_after_pop", {31'b0, tx_valid}, 0);
    step();

    // RX read stalls while the FIFO is empty.
    exp_r.push_back(rexp_t'{32'h5A, 2'b00});
    start_read(4'h0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_axi_rvalid) seen = 1;
      step();
    end
    check("rx_empty_stall", {31'b0, seen}, 0);
    rx_data = 8'h5A; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    wait_valid(1'b1, 40, lat);
    check("rx_stall_release_lat", lat, 2);
    do_read(4'h8, "stat_after_rx");

    // Fill TX with the PHY stalled; the 17th write must wait for a slot.
    for (int i = 0; i < DEPTH; i++)
      do_write(4'h4, i, 4'h1, int'($urandom_range(0, 2)) - 1, "tx_fill");
    do_read(4'h8, "stat_tx_full");
    start_write(4'h4, 32'h10, 4'h1, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_axi_bvalid) seen = 1;
      step();
    end
    check("tx_full_stall", {31'b0, seen}, 0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    wait_valid(1'b0, 10, lat);
    check("tx_full_release_lat", lat, 1);
    tx_ready = 1'b1;
    repeat (20) step();
    tx_ready = 1'b0;
    check("tx_drained", model_tx.size(), 0);
    do_read(4'h8, "stat_tx_drained");

    // Fill RX; a pop with rx_valid held refills it on the following edge.
    for (int i = 0; i < DEPTH; i++) send_rx(8'($urandom_range(0, 255)));
    @(negedge clk);
    check("rx_full_ready", {31'b0, rx_ready}, 0);
    step();
    rx_data = 8'hA5; rx_valid = 1'b1;
    do_read(4'h0, "rx_pop_full");
    rx_valid = 1'b0;
    model_rx.push_back(8'hA5);
    @(negedge clk);
    check("rx_refilled_ready", {31'b0, rx_ready}, 0);
    step();
    do_read(4'h8, "stat_rx_full");
    do_write(4'hC, 32'h2, 4'hF, 0, "rx_flush");
    do_read(4'h8, "stat_rx_flushed");

    // Unmapped addresses: SLVERR without stalling, no state change.
    do_read(4'h7, "bad_read");
    do_write(4'h9, 32'hFF, 4'hF, 0, "bad_write");
    do_read(4'h8, "stat_after_bad");

    // Random traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1: if (model_tx.size() < DEPTH)
                do_write(4'h4, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)) - 1, "rnd_tx");
        2, 3: send_rx(8'($urandom_range(0, 255)));
        4, 5: if (model_rx.size() != 0) do_read(4'h0, "rnd_rx");
        6:    do_read(4'h8, "rnd_stat");
        7: begin
          a = 4'($urandom_range(0, 15));
          if (a[1:0] == 2'b00) a[0] = 1'b1;
          if ($urandom_range(0, 1) == 1) do_read(a, "rnd_bad_read");
          else do_write(a, $urandom, 4'hF, 0, "rnd_bad_write");
        end
        8: begin
          repeat ($urandom_range(1, 6)) begin
            tx_ready = 1'($urandom_range(0, 1));
            step();
          end
          tx_ready = 1'b0;
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_write(4'hC, $urandom_range(0, 3), 4'h1, 0, "rnd_ctrl");
          else do_read(4'hC, "rnd_ctrl_read");
        end
      endcase
    end

    // Reset while a read is stalled and TX holds data.
    do_write(4'hC, 32'h3, 4'h1, 0, "flush_both");
    b = 8'($urandom_range(0, 255));
    do_write(4'h4, {24'b0, b}, 4'h1, 0, "pre_reset_tx");
    start_read(4'h0);
    repeat (3) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_reset_outs();
    model_tx.delete();
    model_rx.delete();
    exp_r.delete();
    exp_b.delete();
    step();
    rst = 1'b0;
    step();
    check_readies_up();
    do_read(4'h8, "stat_after_midreset");
    do_write(4'h4, 32'h77, 4'h1, -1, "post_reset_tx");
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    check("post_reset_drained", model_tx.size(), 0);

    repeat (3) step();
    check("exp_r_left", exp_r.size(), 0);
    check("exp_b_left", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_buffer_axi.md
# uart_buffer_axi

AXI4-Lite responder that terminates the UART window (CPU addresses `0x7F00_000x`) driven by the memory stage's `uart_axi_*` initiator port. It buffers received bytes in an RX FIFO and bytes to send in a TX FIFO, and exposes both as byte streams to the serial PHY. Reads of an empty RX FIFO and writes to a full TX FIFO stall the response, so the core needs no polling loop.

## Interface

Parameters:
- `DEPTH_LOG2`, 4: each FIFO holds `2**DEPTH_LOG2` bytes.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `s_axi_araddr`  in  4  read address.
- `s_axi_arvalid`  in  1  read-address valid.
- `s_axi_arready`  out  1  read-address ready.
- `s_axi_arprot`  in  3  read protection; ignored.
- `s_axi_rdata`  out  32  read data.
- `s_axi_rresp`  out  2  read response.
- `s_axi_rvalid`  out  1  read-data valid.
- `s_axi_rready`  in  1  read-data ready.
- `s_axi_awaddr`  in  4  write address.
- `s_axi_awvalid`  in  1  write-address valid.
- `s_axi_awready`  out  1  write-address ready.
- `s_axi_awprot`  in  3  write protection; ignored.
- `s_axi_wdata`  in  32  write data.
- `s_axi_wstrb`  in  4  write strobes.
- `s_axi_wvalid`  in  1  write-data valid.
- `s_axi_wready`  out  1  write-data ready.
- `s_axi_bresp`  out  2  write response.
- `s_axi_bvalid`  out  1  write-response valid.
- `s_axi_bready`  in  1  write-response ready.
- `rx_data`  in  8  byte from the PHY receiver.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  RX FIFO can accept a byte; equals `!rx_full`.
- `tx_data`  out  8  byte to the PHY transmitter; this is the TX FIFO head.
- `tx_valid`  out  1  TX FIFO is non-empty.
- `tx_ready`  in  1  PHY accepts `tx_data`.

## Operation

Register map. Addresses are `addr[3:0]`. Byte 0 is the only meaningful byte in every register.
- `0x0` RX_FIFO (read)
  - Pops one byte and returns `{24'b0, byte}`.
  - If the FIFO is empty, the response stalls until a byte arrives.
- `0x4` TX_FIFO (write)
  - When `wstrb[0]=1`, pushes `wdata[7:0]`.
  - If the FIFO is full, the response stalls until a slot frees.
  - When `wstrb[0]=0`, nothing is pushed and the response is OKAY.
- `0x8` STAT (read)
  - bit0 RX non-empty, bit1 RX full, bit2 TX empty, bit3 TX full.
  - All other bits read 0.
- `0xC` CTRL (write)
  - bit0 flushes TX, bit1 flushes RX; both are self-clearing.
  - A read of CTRL returns 0.
- Any other address
  - Read returns 0 with SLVERR (`2'b10`); write has no effect and returns SLVERR.
  - Both respond without stalling.

Read FSM:
- `R_IDLE`: `arready=1`. On `arvalid&&arready`, latch the address and go to `R_WAIT`.
- `R_WAIT`: `arready=0`.
  - For an RX_FIFO address with the FIFO empty, stay in `R_WAIT`.
  - Otherwise load `rdata`/`rresp`; a RX_FIFO read pops here. Go to `R_RESP`.
- `R_RESP`: `rvalid=1`; `rdata` is held stable. On `rready`, go to `R_IDLE`.

Write FSM:
- `W_IDLE`:
  - `awready` is 1 until AW is captured; `wready` is 1 until W is captured.
  - AW and W may be captured in either order or in the same cycle.
  - Once both are captured, go to `W_EXEC`.
- `W_EXEC`:
  - A TX_FIFO write with the FIFO full and `wstrb[0]=1` waits here.
  - Otherwise perform the write and go to `W_RESP`.
- `W_RESP`: `bvalid=1`. On `bready`, clear the captured flags and go to `W_IDLE`.

FIFOs:
- Each FIFO is a circular buffer with `DEPTH_LOG2`-bit pointers and a `DEPTH_LOG2+1`-bit count; pointers wrap modulo depth.
- RX push: `rx_valid&&rx_ready`. TX pop: `tx_valid&&tx_ready`.
- Push and pop in the same cycle leave the count unchanged. This is legal when full: on TX, the pop frees the slot first; on RX, `rx_ready` is already 0.
- A flush sets pointers and count to 0 and overrides any same-cycle push or pop on that FIFO.
- The read and write FSMs are independent. A stalled read must not block writes, and a stalled write must not block reads.

## Timing

- Reset, applied at any point including mid-transaction, forces on the next edge:
  - all FSMs to IDLE, all FIFOs empty;
  - `arready`, `awready`, `wready`, `rvalid`, `bvalid` = 0;
  - `rdata` = 0, `rresp` = 0, `bresp` = 0;
  - `tx_valid` = 0, `rx_ready` = 1.
- The `*ready` outputs rise on the first cycle after `rst` falls.
- Read latency, AR handshake at cycle N:
  - `rvalid` rises at N+2 when data is available;
  - otherwise at M+2, where M is the cycle a byte is pushed into RX.
- Write latency, last of AW/W captured at N: the FIFO push happens at edge N+1 and `bvalid` is 1 from N+2.
- Data visibility:
  - A byte pushed into RX at edge K is visible to STAT and to a pop at K+1.
  - A TX push at edge K drives `tx_valid=1` from K+1.
- Exactly one outstanding read and one outstanding write at a time.

## Test plan

- Reset then STAT read:
  - `rdata=0x4` (TX empty), `rresp=0`.
  - `rvalid` at AR+2.
- Write `0x41` to `0x4` with AW one cycle before W:
  - `bvalid` at W+2, `bresp=0`.
  - `tx_valid=1`, `tx_data=0x41`; `tx_ready` pulse then gives `tx_valid=0`.
- RX_FIFO read while empty:
  - `rvalid` stays 0 for 20 cycles.
  - Push `0x5A` on `rx_*`: `rvalid` two cycles later, `rdata=0x0000005A`; STAT then reads 0x4.
- With `tx_ready=0`, write 16 bytes `0x00..0x0F` (`DEPTH_LOG2=4`):
  - STAT bit3=1; a 17th write holds `bvalid=0`.
  - `tx_ready` for one cycle completes the 17th write; the drain order is `0x01..0x0F`, `0x10`.
- Fill RX with 16 bytes:
  - `rx_ready=0`; a same-cycle pop plus `rx_valid` leaves the count at 15 then 16 correctly.
  - CTRL write `0x2` empties RX (STAT bit0=0).
- Read `0x7` and write `0x9`: both give SLVERR with no stall, `rdata=0`, and FIFO state unchanged.
